writeback_unit: RTL and testbench
=================================

# writeback_unit

Drives the write port of the decode-stage register file and tracks which architectural registers still have results outstanding. Two result producers (single-cycle ALU, multi-cycle memory/long-latency unit) hand results in over valid/ready handshakes. A round-robin arbiter selects one per cycle and registers it onto the regfile write port. A per-register busy scoreboard tells decode when an instruction must stall on an unwritten source or destination.

## Interface
- s_width, 32, data width; equals regfile word width
- s_index, 5, register index width; 2**s_index registers; index 0 is hardwired zero
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_dest  in  s_index  ALU destination
- alu_data  in  s_width  ALU result
- mem_valid  in  1  memory/long-latency result offered
- mem_ready  out  1  memory result accepted this cycle
- mem_dest  in  s_index  memory destination
- mem_data  in  s_width  memory result
- issue_valid  in  1  decode wants to issue an instruction
- issue_dest  in  s_index  destination to reserve
- issue_src_a, issue_src_b  in  s_index  sources to check
- issue_stall  out  1  issue blocked this cycle (combinational)
- wb_load  out  1  regfile write enable (connects to regfile load)
- wb_dest  out  s_index  regfile write index
- wb_data  out  s_width  regfile write data
- err_orphan  out  1  sticky: a result arrived for a non-busy, non-zero register

## Operation
- Scoreboard: busy[2**s_index], one bit per register. busy[0] is constant 0.
- issue_stall = issue_valid && (busy[issue_src_a] || busy[issue_src_b] || busy[issue_dest]). Computed from registered busy bits only; no same-cycle bypass.
- Issue fire = issue_valid && !issue_stall. On fire with issue_dest != 0, set busy[issue_dest].
- Arbiter is round-robin with a 1-bit pointer last_grant (ALU=0, MEM=1).
  - Only one valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - last_grant updates to the granted source on every accepted transfer.
- alu_ready / mem_ready equal the grant. They are combinational from the valids and last_grant. The output register always accepts, so there is no backpressure from the regfile.
- Accepted transfer: register the selected dest and data into wb_dest/wb_data.
  - If dest != 0: wb_load = 1 next cycle.
  - If dest == 0: wb_load = 0. The result is consumed and discarded.
- No accepted transfer: wb_load = 0 next cycle. wb_dest and wb_data hold their last values.
- Busy clear: when wb_load is 1, busy[wb_dest] clears on that same edge, together with the regfile write.
  - If a fire sets a register that is being cleared on the same edge, set wins. This cannot occur legally because busy would stall the issue; it is defined anyway.
- err_orphan: set on an accepted transfer with dest != 0 and busy[dest] == 0. Cleared only by rst.

## Timing
- Reset values: busy all 0, last_grant = 1 (ALU wins the first contention), wb_load = 0, wb_dest = 0, wb_data = 0, err_orphan = 0.
- Reset is asynchronous, so assertion mid-operation takes effect immediately. In-flight results are dropped and the scoreboard is cleared. Producers must re-issue after reset.
- Handshake-to-write latency is 1 cycle:
  - Transfer accepted at edge N.
  - wb_load/wb_dest/wb_data are valid during cycle N..N+1.
  - Regfile captures at edge N+1.
  - busy clears at edge N+1.
  - A stalled dependent instruction sees issue_stall = 0 in the cycle after edge N+1, when regfile reads already return the new value.
- Issue-to-stall latency: fire at edge M sets busy at edge M. issue_stall for a dependent instruction is 1 from the cycle after edge M.
- Throughput: one result per cycle. The ALU and MEM each receive at least one grant in every 2 cycles of continuous contention.

## Test plan
- Reset then basic write: issue dest=5 (fire); ALU offers dest=5, data=0xDEADBEEF. Required: alu_ready=1, next cycle wb_load=1, wb_dest=5, wb_data=0xDEADBEEF, then busy[5]=0, err_orphan=0.
- Hazard stall: reserve r3 via issue. Then issue_valid with src_a=3. Required: issue_stall=1 until the cycle after r3 writes back, then 0. The same check must pass with issue_dest=3 (WAW).
- Contention: both producers valid for 4 cycles with distinct reserved dests 1,2,3,4. Required grant order ALU, MEM, ALU, MEM, and four wb_load pulses in consecutive cycles.
- Register zero: ALU result to dest=0. Required: alu_ready=1, wb_load stays 0, err_orphan stays 0. Issue with dest=0 and src=0 never stalls.
- Orphan: MEM result to dest=7 with busy[7]=0. Required: write still occurs (wb_load=1, wb_dest=7), and err_orphan=1 and stays set until rst.
- Mid-operation reset: reserve r9, assert rst while MEM is offering dest=9. Required: all busy cleared immediately, wb_load=0, and issue_stall for src_a=9 is 0 after reset deasserts.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Handshake and write-port bundle between the result producers, decode and the
// writeback unit. The unit takes the slave side; the environment drives the master side.
interface writeback_unit_if #(
    parameter int S_WIDTH = 32,
    parameter int S_INDEX = 5
);
    logic               alu_valid;
    logic               alu_ready;
    logic [S_INDEX-1:0] alu_dest;
    logic [S_WIDTH-1:0] alu_data;

    logic               mem_valid;
    logic               mem_ready;
    logic [S_INDEX-1:0] mem_dest;
    logic [S_WIDTH-1:0] mem_data;

    logic               issue_valid;
    logic [S_INDEX-1:0] issue_dest;
    logic [S_INDEX-1:0] issue_src_a;
    logic [S_INDEX-1:0] issue_src_b;
    logic               issue_stall;

    logic               wb_load;
    logic [S_INDEX-1:0] wb_dest;
    logic [S_WIDTH-1:0] wb_data;
    logic               err_orphan;

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data,
        input  issue_valid, issue_dest, issue_src_a, issue_src_b,
        output alu_ready, mem_ready, issue_stall,
        output wb_load, wb_dest, wb_data, err_orphan
    );

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data,
        output issue_valid, issue_dest, issue_src_a, issue_src_b,
        input  alu_ready, mem_ready, issue_stall,
        input  wb_load, wb_dest, wb_data, err_orphan
    );
endinterface

// File: rtl/writeback_unit.sv
// Round-robin writeback arbiter for two result producers, registered regfile
// write port, and per-register busy scoreboard driving the decode stall.
module writeback_unit #(
    parameter int S_WIDTH = 32,
    parameter int S_INDEX = 5
) (
    input  logic             clk,
    input  logic             rst,
    writeback_unit_if.slave  bus
);
    localparam int NREG = 2 ** S_INDEX;

    logic [NREG-1:0]    busy_q, busy_d;
    logic               last_grant_q, last_grant_d;
    logic               wb_load_q, wb_load_d;
    logic [S_INDEX-1:0] wb_dest_q, wb_dest_d;
    logic [S_WIDTH-1:0] wb_data_q, wb_data_d;
    logic               err_orphan_q, err_orphan_d;

    logic               alu_gnt_s, mem_gnt_s, accept_s;
    logic [S_INDEX-1:0] sel_dest_s;
    logic [S_WIDTH-1:0] sel_data_s;
    logic               stall_s, fire_s;

    // Arbitration: the producer that did not win last time has priority (last_grant 1 = MEM).
    always_comb begin
        alu_gnt_s  = bus.alu_valid && (!bus.mem_valid || last_grant_q);
        mem_gnt_s  = bus.mem_valid && (!bus.alu_valid || !last_grant_q);
        accept_s   = alu_gnt_s || mem_gnt_s;
        sel_dest_s = {S_INDEX{1'b0}};
        sel_data_s = {S_WIDTH{1'b0}};
        if (alu_gnt_s) begin
            sel_dest_s = bus.alu_dest;
            sel_data_s = bus.alu_data;
        end else if (mem_gnt_s) begin
            sel_dest_s = bus.mem_dest;
            sel_data_s = bus.mem_data;
        end else begin
            sel_dest_s = {S_INDEX{1'b0}};
            sel_data_s = {S_WIDTH{1'b0}};
        end
    end

    // Hazard check uses registered busy bits only; a result being written this cycle still stalls.
    always_comb begin
        stall_s = bus.issue_valid && (busy_q[bus.issue_src_a] ||
                                      busy_q[bus.issue_src_b] ||
                                      busy_q[bus.issue_dest]);
        fire_s  = bus.issue_valid && !stall_s;
    end

    // Next-state: clear the register being written back, then apply a new reservation so set wins.
    always_comb begin
        busy_d       = busy_q;
        last_grant_d = last_grant_q;
        wb_load_d    = 1'b0;
        wb_dest_d    = wb_dest_q;
        wb_data_d    = wb_data_q;
        err_orphan_d = err_orphan_q;
        if (wb_load_q) begin
            busy_d[wb_dest_q] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (fire_s && (bus.issue_dest != {S_INDEX{1'b0}})) begin
            busy_d[bus.issue_dest] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
        if (accept_s) begin
            last_grant_d = mem_gnt_s;
            wb_dest_d    = sel_dest_s;
            wb_data_d    = sel_data_s;
            wb_load_d    = (sel_dest_s != {S_INDEX{1'b0}});
            if ((sel_dest_s != {S_INDEX{1'b0}}) && !busy_q[sel_dest_s]) begin
                err_orphan_d = 1'b1;
            end else begin
                err_orphan_d = err_orphan_q;
            end
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // State registers; last_grant resets to MEM so the ALU wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= {NREG{1'b0}};
            last_grant_q <= 1'b1;
            wb_load_q    <= 1'b0;
            wb_dest_q    <= {S_INDEX{1'b0}};
            wb_data_q    <= {S_WIDTH{1'b0}};
            err_orphan_q <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            wb_load_q    <= wb_load_d;
            wb_dest_q    <= wb_dest_d;
            wb_data_q    <= wb_data_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign bus.alu_ready   = alu_gnt_s;
    assign bus.mem_ready   = mem_gnt_s;
    assign bus.issue_stall = stall_s;
    assign bus.wb_load     = wb_load_q;
    assign bus.wb_dest     = wb_dest_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.err_orphan  = err_orphan_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed scenarios plus randomized traffic; a reference model predicts stall,
// grants and orphan flag, and queues expected regfile writes for a separate monitor.
module tb_writeback_unit;
    localparam int W = 32;
    localparam int X = 5;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    writeback_unit_if #(.S_WIDTH(W), .S_INDEX(X)) bus ();

    writeback_unit #(.S_WIDTH(W), .S_INDEX(X)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [X-1:0] dest;
        logic [W-1:0] data;
    } wr_t;

    wr_t sb_q[$];

    // Reference state: which registers have outstanding results, who was served last.
    bit           m_busy[NR];
    bit           m_alu_last;
    bit           m_orphan;
    bit           m_pend;
    int           m_pend_dest;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: compare combinational outputs and flag, then predict the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
            m_alu_last = 1'b0;
            m_orphan   = 1'b0;
            m_pend     = 1'b0;
            sb_q.delete();
            chk("rst_wb_load", {31'd0, bus.wb_load}, 32'd0);
            chk("rst_wb_dest", {27'd0, bus.wb_dest}, 32'd0);
            chk("rst_wb_data", bus.wb_data, 32'd0);
            chk("rst_err_orphan", {31'd0, bus.err_orphan}, 32'd0);
            chk("rst_stall", {31'd0, bus.issue_stall}, 32'd0);
        end else begin
            bit exp_stall, g_alu, g_mem, acc;
            int d;
            logic [W-1:0] v;
            exp_stall = bus.issue_valid && (m_busy[bus.issue_src_a] ||
                        m_busy[bus.issue_src_b] || m_busy[bus.issue_dest]);
            chk("issue_stall", {31'd0, bus.issue_stall}, {31'd0, exp_stall});
            if (bus.alu_valid && bus.mem_valid) begin
                g_alu = !m_alu_last;
            end else begin
                g_alu = bus.alu_valid;
            end
            g_mem = bus.mem_valid && !g_alu;
            chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, g_alu});
            chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, g_mem});
            chk("err_orphan", {31'd0, bus.err_orphan}, {31'd0, m_orphan});
            acc = g_alu || g_mem;
            d   = g_alu ? int'(bus.alu_dest) : int'(bus.mem_dest);
            v   = g_alu ? bus.alu_data : bus.mem_data;
            if (acc) begin
                m_alu_last = g_alu;
                if (d != 0) begin
                    if (!m_busy[d]) m_orphan = 1'b1;
                    sb_q.push_back('{due: cyc + 1, dest: d[X-1:0], data: v});
                end
            end
            if (m_pend) m_busy[m_pend_dest] = 1'b0;
            m_pend      = acc && (d != 0);
            m_pend_dest = d;
            if (bus.issue_valid && !exp_stall && bus.issue_dest != 5'd0)
                m_busy[bus.issue_dest] = 1'b1;
        end
    end

    // Monitor: every regfile write must match the oldest expected write, on time.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_write at cycle %0d: got no write, expected dest %0d data %0h",
                         cyc, sb_q[0].dest, sb_q[0].data);
                void'(sb_q.pop_front());
            end
            if (bus.wb_load) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write at cycle %0d: got dest %0d data %0h, expected none",
                             cyc, bus.wb_dest, bus.wb_data);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    chk("wb_cycle", cyc, e.due);
                    chk("wb_dest", {27'd0, bus.wb_dest}, {27'd0, e.dest});
                    chk("wb_data", bus.wb_data, e.data);
                end
            end
        end
    end

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_dest    = 5'd0;
        bus.alu_data    = 32'd0;
        bus.mem_valid   = 1'b0;
        bus.mem_dest    = 5'd0;
        bus.mem_data    = 32'd0;
        bus.issue_valid = 1'b0;
        bus.issue_dest  = 5'd0;
        bus.issue_src_a = 5'd0;
        bus.issue_src_b = 5'd0;
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [X-1:0] d, input logic [X-1:0] a, input logic [X-1:0] b);
        bus.issue_valid = 1'b1;
        bus.issue_dest  = d;
        bus.issue_src_a = a;
        bus.issue_src_b = b;
    endtask

    task automatic alu(input logic [X-1:0] d, input logic [W-1:0] v);
        bus.alu_valid = 1'b1;
        bus.alu_dest  = d;
        bus.alu_data  = v;
    endtask

    task automatic mem(input logic [X-1:0] d, input logic [W-1:0] v);
        bus.mem_valid = 1'b1;
        bus.mem_dest  = d;
        bus.mem_data  = v;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;

        // Basic write.
        issue(5'd5, 5'd0, 5'd0);            tick();
        idle(); alu(5'd5, 32'hDEADBEEF);    tick();
        idle();                             tick(2);

        // RAW hazard on r3, then WAW on r3.
        issue(5'd3, 5'd0, 5'd0);            tick();
        idle(); issue(5'd10, 5'd3, 5'd0);   tick(3);
        alu(5'd3, 32'h0000_3333);           tick();
        bus.alu_valid = 1'b0;               tick(3);
        idle(); alu(5'd10, 32'h0000_1010);  tick();
        idle(); issue(5'd3, 5'd0, 5'd0);    tick();
        idle(); issue(5'd3, 5'd1, 5'd2);    tick(2);
        mem(5'd3, 32'hCAFE_0003);           tick();
        bus.mem_valid = 1'b0;               tick(3);
        idle(); mem(5'd3, 32'h0000_0333);   tick();
        idle();                             tick(2);

        // Contention after reset: grants ALU, MEM, ALU, MEM.
        do_reset();
        for (int r = 1; r <= 5; r++) begin
            issue(r[X-1:0], 5'd0, 5'd0);    tick();
        end
        idle(); alu(5'd1, 32'hA1); mem(5'd2, 32'hB2); tick();
        alu(5'd3, 32'hA3);                  tick();
        mem(5'd4, 32'hB4);                  tick();
        alu(5'd5, 32'hA5);                  tick();
        bus.mem_valid = 1'b0;               tick();
        idle();                             tick(2);

        // Register zero.
        alu(5'd0, 32'h1234_5678);           tick();
        idle(); issue(5'd0, 5'd0, 5'd0);    tick(2);
        idle();                             tick();

        // Orphan result to r7, flag must stay set.
        mem(5'd7, 32'h7777_7777);           tick();
        idle();                             tick(4);

        // Mid-operation reset while MEM offers r9.
        issue(5'd9, 5'd0, 5'd0);            tick();
        idle(); issue(5'd11, 5'd9, 5'd0); mem(5'd9, 32'h9999_0009);
        #2 rst = 1'b1;
        tick();
        idle(); issue(5'd12, 5'd9, 5'd0);   tick();
        rst = 1'b0;                         tick(3);
        idle();                             tick(2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            idle();
            if ($urandom_range(0, 99) < 45) alu(5'($urandom_range(0, 9)), $urandom);
            if ($urandom_range(0, 99) < 45) mem(5'($urandom_range(0, 9)), $urandom);
            if ($urandom_range(0, 99) < 55)
                issue(5'($urandom_range(0, 9)), 5'($urandom_range(0, 12)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        idle();
        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
